// File: rtl/popcount_pipe.sv
// popcount_pipe
//
// Purpose
//   Three-stage pipelined population count with valid/ready handshaking on
//   both sides:
//     S0  captures the input word and its last flag
//     S1  counts the set bits of each CHUNK-bit slice of the word
//     S2  sums the chunk counts and registers every output
//   A stall at the output ripples back through the stage chain within the
//   same cycle. An empty stage always loads, so bubbles never block traffic.
//
// Build option
//   POPCNT_ACC_EN  When defined, a running saturating burst total is kept
//                  in acc/sat. A beat with last = 1 closes the burst.
//                  When undefined, no accumulator is built: out_sum is
//                  out_cnt zero-extended and out_sat is constant 0.
//                  The port list is the same in both builds.
//
// Parameters
//   WIDTH  input word width, a multiple of CHUNK                (default 32)
//   CHUNK  bits counted per S1 chunk counter, 2..16              (default 8)
//   ACC_W  width of out_sum, at least $clog2(WIDTH+1)           (default 16)
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   input beat valid
//   in_ready   out  a beat can be accepted this cycle (combinational from out_ready)
//   in_data    in   WIDTH-bit word to count
//   in_last    in   beat closes an accumulation burst
//   out_valid  out  result valid
//   out_ready  in   downstream accepts the result
//   out_cnt    out  popcount of the beat, $clog2(WIDTH+1) bits
//   out_sum    out  burst running sum (or out_cnt when accumulation is off)
//   out_last   out  in_last of the beat, delayed through the pipe
//   out_sat    out  burst total has saturated (0 when accumulation is off)

module popcount_pipe #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int ACC_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(WIDTH+1)-1:0] out_cnt,
    output logic [ACC_W-1:0]           out_sum,
    output logic                       out_last,
    output logic                       out_sat
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int NCH   = WIDTH / CHUNK;
    localparam int CC_W  = $clog2(CHUNK + 1);

    // ------------------------------------------------------------------
    // Stage valid bits and load enables
    // ------------------------------------------------------------------
    logic v0;
    logic v1;
    logic v2;
    logic ld0;
    logic ld1;
    logic ld2;

    // Each stage loads when it is empty or when the stage after it is
    // loading; the chain runs from out_ready back to in_ready in one cycle.
    assign ld2      = !v2 || out_ready;
    assign ld1      = !v1 || ld2;
    assign ld0      = !v0 || ld1;
    assign in_ready = ld0;

    // ------------------------------------------------------------------
    // S0: input capture
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] s0_data;
    logic             s0_last;

    // Data is written only for real beats, so a bubble entering S0 leaves
    // the previous word in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0      <= 1'b0;
            s0_data <= '0;
            s0_last <= 1'b0;
        end else if (ld0) begin
            v0 <= in_valid;
            if (in_valid) begin
                s0_data <= in_data;
                s0_last <= in_last;
            end
        end
    end

    // ------------------------------------------------------------------
    // S1: per-chunk counts
    // ------------------------------------------------------------------
    logic [CC_W-1:0] chunk_cnt [NCH];
    logic [CC_W-1:0] s1_cnt    [NCH];
    logic            s1_last;

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            chunk_cnt[c] = '0;
            for (int b = 0; b < CHUNK; b++) begin
                chunk_cnt[c] = chunk_cnt[c] + CC_W'(s0_data[c*CHUNK + b]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1      <= 1'b0;
            s1_last <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                s1_cnt[c] <= '0;
            end
        end else if (ld1) begin
            v1 <= v0;
            if (v0) begin
                s1_last <= s0_last;
                for (int c = 0; c < NCH; c++) begin
                    s1_cnt[c] <= chunk_cnt[c];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: chunk sum and output registers
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_sum;
    logic [CNT_W-1:0] out_cnt_r;
    logic             out_last_r;

    // The sum of all chunk counts is at most WIDTH, so CNT_W bits never
    // overflow.
    always_comb begin
        cnt_sum = '0;
        for (int c = 0; c < NCH; c++) begin
            cnt_sum = cnt_sum + CNT_W'(s1_cnt[c]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2         <= 1'b0;
            out_cnt_r  <= '0;
            out_last_r <= 1'b0;
        end else if (ld2) begin
            v2 <= v1;
            if (v1) begin
                out_cnt_r  <= cnt_sum;
                out_last_r <= s1_last;
            end
        end
    end

    assign out_valid = v2;
    assign out_cnt   = out_cnt_r;
    assign out_last  = out_last_r;

`ifdef POPCNT_ACC_EN
    // ------------------------------------------------------------------
    // Burst accumulator
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] acc;
    logic             sat;
    logic [ACC_W:0]   cnt_ext;
    logic [ACC_W:0]   acc_total;
    logic             acc_over;
    logic [ACC_W-1:0] sum_next;
    logic             sat_next;
    logic [ACC_W-1:0] out_sum_r;
    logic             out_sat_r;

    // The add is one bit wider than acc. The carry only flags saturation
    // and is never stored.
    always_comb begin
        cnt_ext               = '0;
        cnt_ext[CNT_W-1:0]    = cnt_sum;
        acc_total             = {1'b0, acc} + cnt_ext;
        acc_over              = acc_total[ACC_W];
        sum_next              = acc_over ? {ACC_W{1'b1}} : acc_total[ACC_W-1:0];
        sat_next              = sat || acc_over;
    end

    // A closing beat still reports its own total on the outputs, while the
    // running state restarts from zero for the next burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            sat       <= 1'b0;
            out_sum_r <= '0;
            out_sat_r <= 1'b0;
        end else if (ld2 && v1) begin
            out_sum_r <= sum_next;
            out_sat_r <= sat_next;
            if (s1_last) begin
                acc <= '0;
                sat <= 1'b0;
            end else begin
                acc <= sum_next;
                sat <= sat_next;
            end
        end
    end

    assign out_sum = out_sum_r;
    assign out_sat = out_sat_r;
`else
    // ------------------------------------------------------------------
    // No accumulator: out_sum mirrors the beat count
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] sum_ext;

    always_comb begin
        sum_ext            = '0;
        sum_ext[CNT_W-1:0] = out_cnt_r;
    end

    assign out_sum = sum_ext;
    assign out_sat = 1'b0;
`endif

endmodule

// File: tb/tb_popcount_pipe.sv
// tb_popcount_pipe
//
// Self-checking bench for popcount_pipe (WIDTH=32, CHUNK=8, ACC_W=6 so that
// saturation is reachable in a few beats). Expected results come from a
// queue-based model that counts bits with $countones and applies the
// burst/saturation rules with plain integer arithmetic.

module tb_popcount_pipe;

    localparam int WIDTH  = 32;
    localparam int CHUNK  = 8;
    localparam int ACC_W  = 6;
    localparam int CNT_W  = $clog2(WIDTH + 1);
    localparam int MAXSUM = (1 << ACC_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_cnt;
    logic [ACC_W-1:0] out_sum;
    logic             out_last;
    logic             out_sat;

    popcount_pipe #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK),
        .ACC_W (ACC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_cnt   (out_cnt),
        .out_sum   (out_sum),
        .out_last  (out_last),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit valid;
        int cnt;
        int sum;
        bit last;
        bit sat;
    } res_t;

    res_t mq[$];
    int   m_acc;
    bit   m_sat;
    int   total;
    int   bad;

    // Reference model: one entry per accepted beat, in acceptance order.
    function automatic void model_push(input logic [WIDTH-1:0] d, input bit l);
        res_t r;
        r.valid = 1'b1;
        r.cnt   = $countones(d);
        r.last  = l;
`ifdef POPCNT_ACC_EN
        begin
            int t;
            t     = m_acc + r.cnt;
            r.sum = (t > MAXSUM) ? MAXSUM : t;
            r.sat = m_sat || (t > MAXSUM);
            if (l) begin
                m_acc = 0;
                m_sat = 1'b0;
            end else begin
                m_acc = r.sum;
                m_sat = r.sat;
            end
        end
`else
        r.sum = r.cnt;
        r.sat = 1'b0;
`endif
        mq.push_back(r);
    endfunction

    // Drives one cycle at the falling edge and samples the DUT 1 ns later.
    task automatic cyc(input bit v, input logic [WIDTH-1:0] d, input bit l, input bit r,
                       output bit acc_o, output bit drn_o, output bit rdy_o, output res_t got);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        #1;
        rdy_o     = in_ready;
        acc_o     = v && in_ready;
        drn_o     = out_valid && r;
        got.valid = out_valid;
        got.cnt   = int'(out_cnt);
        got.sum   = int'(out_sum);
        got.last  = out_last;
        got.sat   = out_sat;
        if (acc_o) model_push(d, l);
    endtask

    task automatic test_reset();
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        #2 rst_n  = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if ({out_valid, out_last, out_sat} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL reset_flags: valid/last/sat=%b required 000", {out_valid, out_last, out_sat});
        end
        total++;
        if (out_cnt !== '0) begin
            bad++;
            $display("[TB] FAIL reset_cnt: out_cnt=%0d required 0", out_cnt);
        end
        total++;
        if (out_sum !== '0) begin
            bad++;
            $display("[TB] FAIL reset_sum: out_sum=%0d required 0", out_sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_acc = 0;
        m_sat = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_in_ready: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_single();
        bit a, d, rd;
        res_t got, exp;
        int lat;
        cyc(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, a, d, rd, got);
        total++;
        if (a !== 1'b1 || rd !== 1'b1) begin
            bad++;
            $display("[TB] FAIL single_accept: accepted=%b required 1", a);
        end
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            cyc(1'b0, '0, 1'b0, 1'b1, a, d, rd, got);
            if (d && lat == 0) begin
                lat = i;
                total++;
                if (mq.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL single_extra: unexpected result cnt=%0d", got.cnt);
                end else begin
                    exp = mq.pop_front();
                    if (got.cnt !== exp.cnt || got.sum !== exp.sum || got.last !== exp.last || got.sat !== exp.sat
                        || got.cnt !== 32 || got.sum !== 32 || got.last !== 1'b1) begin
                        bad++;
                        $display("[TB] FAIL single_result: got cnt=%0d sum=%0d last=%0b sat=%0b required cnt=32 sum=32 last=1 sat=%0b",
                                 got.cnt, got.sum, got.last, got.sat, exp.sat);
                    end
                end
            end
        end
        total++;
        if (lat !== 3) begin
            bad++;
            $display("[TB] FAIL single_latency: latency=%0d cycles required 3", lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] data [4];
        int   exp_cnt [4];
        bit   a, d, rd;
        res_t got, exp;
        int   prev, n;
        data    = '{32'h0000_0000, 32'h0000_0001, 32'h8000_0001, 32'hF0F0_F0F0};
        exp_cnt = '{0, 1, 2, 16};
        prev = -1;
        n    = 0;
        for (int i = 0; i < 14; i++) begin
            if (i < 4) cyc(1'b1, data[i], i == 3, 1'b1, a, d, rd, got);
            else       cyc(1'b0, '0, 1'b0, 1'b1, a, d, rd, got);
            if (i < 4) begin
                total++;
                if (rd !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL b2b_in_ready: cycle %0d in_ready=%b required 1", i, rd);
                end
            end
            if (d) begin
                total++;
                if (mq.size() == 0 || n >= 4) begin
                    bad++;
                    $display("[TB] FAIL b2b_extra: unexpected result cnt=%0d", got.cnt);
                end else begin
                    exp = mq.pop_front();
                    if (got.cnt !== exp.cnt || got.sum !== exp.sum || got.last !== exp.last || got.sat !== exp.sat
                        || got.cnt !== exp_cnt[n]) begin
                        bad++;
                        $display("[TB] FAIL b2b_result: got cnt=%0d sum=%0d last=%0b sat=%0b required cnt=%0d sum=%0d last=%0b sat=%0b",
                                 got.cnt, got.sum, got.last, got.sat, exp_cnt[n], exp.sum, exp.last, exp.sat);
                    end
                end
                if (prev >= 0) begin
                    total++;
                    if (i != prev + 1) begin
                        bad++;
                        $display("[TB] FAIL b2b_gap: result at cycle %0d, previous at %0d", i, prev);
                    end
                end
                prev = i;
                n++;
            end
        end
        total++;
        if (n != 4) begin
            bad++;
            $display("[TB] FAIL b2b_count: results=%0d required 4", n);
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] bp_data [6];
        bit   a, d, rd, r, stalled_prev, saw_full;
        res_t got, exp, prev_got;
        int   sent, infl, i;
        for (int k = 0; k < 6; k++) bp_data[k] = $urandom;
        sent         = 0;
        stalled_prev = 1'b0;
        saw_full     = 1'b0;
        prev_got     = '{default: 0};
        i            = 0;
        while (i < 60 && (sent < 6 || mq.size() > 0)) begin
            r    = !(i >= 3 && i <= 8);
            infl = mq.size();
            cyc(sent < 6, (sent < 6) ? bp_data[sent] : '0, sent == 5, r, a, d, rd, got);
            if (a) sent++;
            if (infl == 3 && !r) saw_full = 1'b1;
            total++;
            if (rd !== ((infl < 3) || r)) begin
                bad++;
                $display("[TB] FAIL bp_in_ready: cycle %0d in_ready=%b required %b (in flight %0d)", i, rd, (infl < 3) || r, infl);
            end
            if (stalled_prev) begin
                total++;
                if (got.valid !== 1'b1 || got.cnt !== prev_got.cnt || got.sum !== prev_got.sum
                    || got.last !== prev_got.last || got.sat !== prev_got.sat) begin
                    bad++;
                    $display("[TB] FAIL bp_stable: cycle %0d got valid=%0b cnt=%0d sum=%0d required held cnt=%0d sum=%0d",
                             i, got.valid, got.cnt, got.sum, prev_got.cnt, prev_got.sum);
                end
            end
            stalled_prev = got.valid && !r;
            prev_got     = got;
            if (d) begin
                total++;
                if (mq.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL bp_extra: unexpected result cnt=%0d", got.cnt);
                end else begin
                    exp = mq.pop_front();
                    if (got.cnt !== exp.cnt || got.sum !== exp.sum || got.last !== exp.last || got.sat !== exp.sat) begin
                        bad++;
                        $display("[TB] FAIL bp_result: got cnt=%0d sum=%0d last=%0b sat=%0b required cnt=%0d sum=%0d last=%0b sat=%0b",
                                 got.cnt, got.sum, got.last, got.sat, exp.cnt, exp.sum, exp.last, exp.sat);
                    end
                end
            end
            i++;
        end
        total++;
        if (sent != 6 || mq.size() != 0 || !saw_full) begin
            bad++;
            $display("[TB] FAIL bp_complete: sent=%0d pending=%0d full_seen=%0b required 6/0/1", sent, mq.size(), saw_full);
        end
    endtask

    task automatic test_burst();
        logic [WIDTH-1:0] data [4];
        bit   lasts [4];
        int   exp_sum [4];
        bit   a, d, rd;
        res_t got, exp;
        int   n;
        data  = '{32'h0000_00FF, 32'h0000_FF00, 32'hFF00_0000, 32'h0000_000F};
        lasts = '{1'b0, 1'b0, 1'b1, 1'b1};
`ifdef POPCNT_ACC_EN
        exp_sum = '{8, 16, 24, 4};
`else
        exp_sum = '{8, 8, 8, 4};
`endif
        n = 0;
        for (int i = 0; i < 14; i++) begin
            if (i < 4) cyc(1'b1, data[i], lasts[i], 1'b1, a, d, rd, got);
            else       cyc(1'b0, '0, 1'b0, 1'b1, a, d, rd, got);
            if (d) begin
                total++;
                if (mq.size() == 0 || n >= 4) begin
                    bad++;
                    $display("[TB] FAIL burst_extra: unexpected result cnt=%0d", got.cnt);
                end else begin
                    exp = mq.pop_front();
                    if (got.cnt !== exp.cnt || got.sum !== exp.sum || got.last !== exp.last || got.sat !== exp.sat
                        || got.sum !== exp_sum[n] || got.last !== lasts[n]) begin
                        bad++;
                        $display("[TB] FAIL burst_result: beat %0d got sum=%0d last=%0b sat=%0b required sum=%0d last=%0b sat=%0b",
                                 n, got.sum, got.last, got.sat, exp_sum[n], lasts[n], exp.sat);
                    end
                end
                n++;
            end
        end
        total++;
        if (n != 4 || rd !== 1'b1) begin
            bad++;
            $display("[TB] FAIL burst_count: results=%0d required 4", n);
        end
    endtask

    task automatic test_saturation();
        logic [WIDTH-1:0] data [4];
        bit   lasts [4];
        int   exp_sum [4];
        bit   exp_sat [4];
        bit   a, d, rd;
        res_t got, exp;
        int   n;
        data  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0003};
        lasts = '{1'b0, 1'b0, 1'b1, 1'b1};
`ifdef POPCNT_ACC_EN
        exp_sum = '{32, 63, 63, 2};
        exp_sat = '{1'b0, 1'b1, 1'b1, 1'b0};
`else
        exp_sum = '{32, 32, 32, 2};
        exp_sat = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        n = 0;
        for (int i = 0; i < 14; i++) begin
            if (i < 4) cyc(1'b1, data[i], lasts[i], 1'b1, a, d, rd, got);
            else       cyc(1'b0, '0, 1'b0, 1'b1, a, d, rd, got);
            if (d) begin
                total++;
                if (mq.size() == 0 || n >= 4) begin
                    bad++;
                    $display("[TB] FAIL sat_extra: unexpected result cnt=%0d", got.cnt);
                end else begin
                    exp = mq.pop_front();
                    if (got.cnt !== exp.cnt || got.sum !== exp.sum || got.last !== exp.last || got.sat !== exp.sat
                        || got.sum !== exp_sum[n] || got.sat !== exp_sat[n]) begin
                        bad++;
                        $display("[TB] FAIL sat_result: beat %0d got sum=%0d sat=%0b required sum=%0d sat=%0b",
                                 n, got.sum, got.sat, exp_sum[n], exp_sat[n]);
                    end
                end
                n++;
            end
        end
        total++;
        if (n != 4 || rd !== 1'b1) begin
            bad++;
            $display("[TB] FAIL sat_count: results=%0d required 4", n);
        end
    endtask

    task automatic test_reset_midflight();
        bit   a, d, rd;
        res_t got, exp;
        int   n;
        for (int i = 0; i < 3; i++) cyc(1'b1, $urandom, 1'b0, 1'b0, a, d, rd, got);
        cyc(1'b0, '0, 1'b0, 1'b0, a, d, rd, got);
        total++;
        if (got.valid !== 1'b1 || rd !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midrst_full: out_valid=%b in_ready=%b required 1/0", got.valid, rd);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, out_last, out_sat} !== 3'b000 || out_cnt !== '0 || out_sum !== '0) begin
            bad++;
            $display("[TB] FAIL midrst_outputs: valid=%b cnt=%0d sum=%0d last=%b sat=%b required all 0",
                     out_valid, out_cnt, out_sum, out_last, out_sat);
        end
        mq.delete();
        m_acc = 0;
        m_sat = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 0)      cyc(1'b1, 32'h0000_001F, 1'b0, 1'b1, a, d, rd, got);
            else if (i == 1) cyc(1'b1, 32'h0000_0000, 1'b1, 1'b1, a, d, rd, got);
            else             cyc(1'b0, '0, 1'b0, 1'b1, a, d, rd, got);
            if (d) begin
                total++;
                if (mq.size() == 0 || n >= 2) begin
                    bad++;
                    $display("[TB] FAIL midrst_extra: unexpected result cnt=%0d", got.cnt);
                end else begin
                    exp = mq.pop_front();
                    // Both beats report 5: the count-5 beat opens a fresh
                    // burst, the empty closing beat reports the held total.
                    if (got.cnt !== exp.cnt || got.sum !== exp.sum || got.last !== exp.last || got.sat !== exp.sat
`ifdef POPCNT_ACC_EN
                        || got.sum !== 5
`else
                        || got.sum !== ((n == 0) ? 5 : 0)
`endif
                        ) begin
                        bad++;
                        $display("[TB] FAIL midrst_result: beat %0d got cnt=%0d sum=%0d last=%0b required cnt=%0d sum=%0d last=%0b",
                                 n, got.cnt, got.sum, got.last, exp.cnt, exp.sum, exp.last);
                    end
                end
                n++;
            end
        end
        total++;
        if (n != 2) begin
            bad++;
            $display("[TB] FAIL midrst_count: results=%0d required 2", n);
        end
    endtask

    task automatic test_random();
        bit   a, d, rd, v, r, l;
        res_t got, exp;
        int   infl, i;
        logic [WIDTH-1:0] w;
        i = 0;
        while (i < 400 || (mq.size() > 0 && i < 430)) begin
            v    = (i < 400) && ($urandom_range(0, 3) != 0);
            r    = (i >= 400) || ($urandom_range(0, 3) != 0);
            l    = (i == 399) || ($urandom_range(0, 5) == 0);
            w    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : WIDTH'($urandom);
            infl = mq.size();
            cyc(v, w, l, r, a, d, rd, got);
            total++;
            if (rd !== ((infl < 3) || r)) begin
                bad++;
                $display("[TB] FAIL rand_in_ready: cycle %0d in_ready=%b required %b", i, rd, (infl < 3) || r);
            end
            if (d) begin
                total++;
                if (mq.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL rand_extra: unexpected result cnt=%0d", got.cnt);
                end else begin
                    exp = mq.pop_front();
                    if (got.cnt !== exp.cnt || got.sum !== exp.sum || got.last !== exp.last || got.sat !== exp.sat) begin
                        bad++;
                        $display("[TB] FAIL rand_result: cycle %0d got cnt=%0d sum=%0d last=%0b sat=%0b required cnt=%0d sum=%0d last=%0b sat=%0b",
                                 i, got.cnt, got.sum, got.last, got.sat, exp.cnt, exp.sum, exp.last, exp.sat);
                    end
                end
            end
            i++;
        end
        total++;
        if (mq.size() != 0) begin
            bad++;
            $display("[TB] FAIL rand_drain: %0d results never appeared", mq.size());
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        m_acc = 0;
        m_sat = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_burst();
        test_saturation();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
